// File: rtl/instr_encoder_loader.sv
// Encodes symbolic MIPS operations into machine words and streams them into IM.
// Optional delay-slot padding after branches/jumps: define INSTR_ENC_DELAY_SLOT_EN.
module instr_encoder_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter int          DEPTH     = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op_sel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    input  logic        finish,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic [10:0] word_cnt,
    output logic        full,
    output logic        err,
    output logic        done
);

    localparam logic [10:0] DEPTH_C = 11'(DEPTH);

`ifdef INSTR_ENC_DELAY_SLOT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, SLOT = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, DONE = 2'd3} state_t;
`endif

    state_t      state_q, state_d;
    logic        im_we_q, im_we_d;
    logic [31:0] im_addr_q, im_addr_d;
    logic [31:0] im_wdata_q, im_wdata_d;
    logic [10:0] word_cnt_q, word_cnt_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic        full_s;
`ifdef INSTR_ENC_DELAY_SLOT_EN
    logic        branch_q, branch_d;
`endif

    function automatic logic op_legal(input logic [3:0] op);
        return (op <= 4'd9);
    endfunction

    function automatic logic op_is_branch(input logic [3:0] op);
        return (op == 4'd5) || (op == 4'd7) || (op == 4'd8) || (op == 4'd9);
    endfunction

    // Illegal selectors encode as an all-zero nop word.
    function automatic logic [31:0] encode_instr(
        input logic [3:0]  op,
        input logic [4:0]  rs_i,
        input logic [4:0]  rt_i,
        input logic [4:0]  rd_i,
        input logic [15:0] imm_i,
        input logic [25:0] tgt_i
    );
        logic [31:0] w;
        case (op)
            4'd0:    w = {6'b000000, rs_i, rt_i, rd_i, 5'b00000, 6'b100001};
            4'd1:    w = {6'b000000, rs_i, rt_i, rd_i, 5'b00000, 6'b100011};
            4'd2:    w = {6'b001101, rs_i, rt_i, imm_i};
            4'd3:    w = {6'b100011, rs_i, rt_i, imm_i};
            4'd4:    w = {6'b101011, rs_i, rt_i, imm_i};
            4'd5:    w = {6'b000100, rs_i, rt_i, imm_i};
            4'd6:    w = {6'b001111, 5'b00000, rt_i, imm_i};
            4'd7:    w = {6'b000011, tgt_i};
            4'd8:    w = {6'b000000, rs_i, 15'b0, 6'b001000};
            4'd9:    w = {6'b000010, tgt_i};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    assign full_s   = (word_cnt_q == DEPTH_C);
    assign in_ready = (state_q == IDLE) && !full_s && !done_q;

    // Next-state and next-output computation for the write sequencer.
    always_comb begin
        state_d    = state_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        word_cnt_d = word_cnt_q;
        err_d      = err_q;
        done_d     = done_q;
`ifdef INSTR_ENC_DELAY_SLOT_EN
        branch_d   = branch_q;
`endif
        case (state_q)
            IDLE: begin
                // finish has priority over a simultaneous request
                if (finish) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (in_valid && in_ready) begin
                    state_d    = WRITE;
                    im_we_d    = 1'b1;
                    im_wdata_d = encode_instr(op_sel, rs, rt, rd, imm, target);
                    err_d      = err_q | !op_legal(op_sel);
`ifdef INSTR_ENC_DELAY_SLOT_EN
                    branch_d   = op_is_branch(op_sel);
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                im_addr_d  = im_addr_q + 32'd4;
                word_cnt_d = word_cnt_q + 11'd1;
                state_d    = IDLE;
`ifdef INSTR_ENC_DELAY_SLOT_EN
                // A branch that took the last word loses its slot and flags it.
                if (branch_q) begin
                    if ((word_cnt_q + 11'd1) < DEPTH_C) begin
                        state_d    = SLOT;
                        im_we_d    = 1'b1;
                        im_wdata_d = 32'h0000_0000;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
`endif
            end
`ifdef INSTR_ENC_DELAY_SLOT_EN
            SLOT: begin
                im_addr_d  = im_addr_q + 32'd4;
                word_cnt_d = word_cnt_q + 11'd1;
                state_d    = IDLE;
            end
`endif
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset also cancels any in-flight write pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            im_we_q    <= 1'b0;
            im_addr_q  <= BASE_ADDR;
            im_wdata_q <= 32'h0000_0000;
            word_cnt_q <= 11'd0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
`ifdef INSTR_ENC_DELAY_SLOT_EN
            branch_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
            word_cnt_q <= word_cnt_d;
            err_q      <= err_d;
            done_q     <= done_d;
`ifdef INSTR_ENC_DELAY_SLOT_EN
            branch_q   <= branch_d;
`endif
        end
    end

    assign im_we    = im_we_q;
    assign im_addr  = im_addr_q;
    assign im_wdata = im_wdata_q;
    assign word_cnt = word_cnt_q;
    assign full     = full_s;
    assign err      = err_q;
    assign done     = done_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: scoreboard of expected IM writes plus a DEPTH=4 instance.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reset4 = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  op_sel = 4'd0;
    logic [4:0]  rs = 5'd0, rt = 5'd0, rd = 5'd0;
    logic [15:0] imm = 16'd0;
    logic [25:0] target = 26'd0;
    logic        finish = 1'b0;

    logic        in_ready, im_we, full, err, done;
    logic [31:0] im_addr, im_wdata;
    logic [10:0] word_cnt;
    logic        in_ready4, im_we4, full4, err4, done4;
    logic [31:0] im_addr4, im_wdata4;
    logic [10:0] word_cnt4;

    int nchk = 0;
    int nfail = 0;
    int writes4 = 0;
    logic [63:0] sb[$];
    logic [31:0] addr_m = 32'h0000_3000;
    logic [10:0] cnt_m = 11'd0;

    always #5 clk = ~clk;

    instr_encoder_loader dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
        .finish(finish), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .word_cnt(word_cnt), .full(full), .err(err), .done(done)
    );

    instr_encoder_loader #(.BASE_ADDR(32'h0000_3000), .DEPTH(4)) dut4 (
        .clk(clk), .reset(reset4), .in_valid(in_valid), .in_ready(in_ready4),
        .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
        .finish(finish), .im_we(im_we4), .im_addr(im_addr4), .im_wdata(im_wdata4),
        .word_cnt(word_cnt4), .full(full4), .err(err4), .done(done4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Write monitor: every im_we pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [63:0] e;
        if (im_we === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("im_addr", im_addr, e[63:32]);
                check("im_wdata", im_wdata, e[31:0]);
            end
        end
        if (im_we4 === 1'b1) begin
            check("im_addr4", im_addr4, 32'h0000_3000 + 32'(writes4 * 4));
            check("im_wdata4", im_wdata4, 32'h0022_1821);
            writes4++;
        end
    end

    task automatic send(input logic [3:0] op, input logic [4:0] rs_i, input logic [4:0] rt_i,
                        input logic [4:0] rd_i, input logic [15:0] imm_i, input logic [25:0] tg_i,
                        input logic [31:0] exp_w);
        int n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {31'd0, in_ready}, 32'd1);
        op_sel = op; rs = rs_i; rt = rt_i; rd = rd_i; imm = imm_i; target = tg_i;
        in_valid = 1'b1;
        sb.push_back({addr_m, exp_w});
        addr_m += 32'd4;
        cnt_m  += 11'd1;
`ifdef INSTR_ENC_DELAY_SLOT_EN
        if (op == 4'd5 || op == 4'd7 || op == 4'd8 || op == 4'd9) begin
            sb.push_back({addr_m, 32'h0000_0000});
            addr_m += 32'd4;
            cnt_m  += 11'd1;
        end
`endif
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("ready_low_in_write", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("drain_empty", sb.size(), 32'd0);
        check("word_cnt", {21'd0, word_cnt}, {21'd0, cnt_m});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_im_we", {31'd0, im_we}, 32'd0);
        check("rst_im_addr", im_addr, 32'h0000_3000);
        check("rst_im_wdata", im_wdata, 32'd0);
        check("rst_word_cnt", {21'd0, word_cnt}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 26'd0, 32'h0022_1821);
        drain();
        send(4'd2, 5'd0, 5'd1, 5'd9, 16'h1234, 26'd0, 32'h3401_1234);
        send(4'd6, 5'd7, 5'd8, 5'd0, 16'hFFFF, 26'd0, 32'h3C08_FFFF);
        drain();
        send(4'd7, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h000_0C03, 32'h0C00_0C03);
        send(4'd8, 5'd31, 5'd0, 5'd0, 16'h0000, 26'd0, 32'h03E0_0008);
        send(4'd5, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'd0, 32'h1022_FFFF);
        drain();
        check("err_after_legal", {31'd0, err}, 32'd0);

        send(4'd12, 5'd3, 5'd4, 5'd5, 16'hABCD, 26'h3FF_FFFF, 32'h0000_0000);
        drain();
        check("err_illegal", {31'd0, err}, 32'd1);
        send(4'd1, 5'd4, 5'd5, 5'd6, 16'h0000, 26'd0, 32'h0085_3023);
        send(4'd4, 5'd29, 5'd31, 5'd0, 16'h0010, 26'd0, 32'hAFBF_0010);
        drain();
        check("err_sticky", {31'd0, err}, 32'd1);

        // Reset lands in the WRITE cycle: pulse must vanish, nothing is scored.
        @(negedge clk);
        op_sel = 4'd0; rs = 5'd1; rt = 5'd2; rd = 5'd3; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("pre_rst_we", {31'd0, im_we}, 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_we", {31'd0, im_we}, 32'd0);
        check("midrst_addr", im_addr, 32'h0000_3000);
        check("midrst_cnt", {21'd0, word_cnt}, 32'd0);
        check("midrst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        addr_m = 32'h0000_3000;
        cnt_m  = 11'd0;

        @(negedge clk);
        finish = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 finish = 1'b0; in_valid = 1'b0;
        check("finish_done", {31'd0, done}, 32'd1);
        check("finish_ready", {31'd0, in_ready}, 32'd0);
        repeat (3) @(negedge clk);
        check("finish_no_write_cnt", {21'd0, word_cnt}, 32'd0);
        check("finish_sb_empty", sb.size(), 32'd0);

        // DEPTH=4 instance; the main instance sits in DONE and ignores everything.
        reset4 = 1'b0;
        op_sel = 4'd0; rs = 5'd1; rt = 5'd2; rd = 5'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 4) begin
                check("d4_full", {31'd0, full4}, 32'd1);
                check("d4_cnt_full", {21'd0, word_cnt4}, 32'd4);
                check("d4_addr_hold", im_addr4, 32'h0000_3010);
                check("d4_ready_full", {31'd0, in_ready4}, 32'd0);
            end
            in_valid = 1'b1;
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("d4_writes", writes4, 32'd4);
        check("d4_cnt_after5", {21'd0, word_cnt4}, 32'd4);
        check("d4_err", {31'd0, err4}, 32'd0);
        check("d4_done_before", {31'd0, done4}, 32'd0);
        finish = 1'b1;
        @(posedge clk);
        #1 finish = 1'b0;
        check("d4_done", {31'd0, done4}, 32'd1);
        repeat (2) @(negedge clk);
        check("main_no_write", {21'd0, word_cnt}, 32'd0);
        check("final_sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
